// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter: FSM states, latched memory op and grant identity.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

  // Encoding matters: 0 = I-cache, 1 = D-cache, matching the last_grant bit.
  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  // Bit positions in the two-entry request/grant vectors.
  localparam int unsigned REQ_I = 0;
  localparam int unsigned REQ_D = 1;

  // A D-cache request with both strobes high is treated as a write.
  function automatic arb_op_t d_op(input logic rd, input logic wr);
    arb_op_t op;
    op = OP_READ;
    if (wr) begin
      op = OP_WRITE;
    end else if (rd) begin
      op = OP_READ;
    end
    return op;
  endfunction

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory cacheline ports around the arbiter.
interface cacheline_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);

  // I-cache client (read only)
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  // D-cache client (read / write)
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  // Shared physical-memory port
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // Arbiter side.
  modport master (
    input  i_read,
    input  i_address,
    output i_rdata,
    output i_resp,
    input  d_read,
    input  d_write,
    input  d_address,
    input  d_wdata,
    output d_rdata,
    output d_resp,
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_rdata,
    input  pmem_resp
  );

  // Environment side: the two caches plus memory.
  modport slave (
    output i_read,
    output i_address,
    input  i_rdata,
    input  i_resp,
    output d_read,
    output d_write,
    output d_address,
    output d_wdata,
    input  d_rdata,
    input  d_resp,
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_rdata,
    output pmem_resp
  );

endinterface

// File: rtl/cacheline_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie, grants the requester that did not win last.
module rr_pick2
  import arbiter_types::*;
(
  input  logic [1:0] req,
  input  grant_t     last,
  output logic [1:0] gnt,
  output logic       valid
);

  // One-hot grant selection; a tie goes to the client opposite the previous winner.
  always_comb begin
    gnt   = 2'b00;
    valid = |req;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == GRANT_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline memory port between the I-cache and D-cache. One client is granted at a
// time; its request is latched and driven to memory until pmem_resp, which is routed straight
// back to that client in the same cycle. A mandatory IDLE cycle separates consecutive grants.
module cacheline_arbiter
  import arbiter_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input logic               clk,
  input logic               rst,
  cacheline_arbiter_if.master bus
);

  arb_state_t        state_q, state_d;
  grant_t            last_q, last_d;
  arb_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_valid;
  logic       busy;

  // Pending requests are only sampled in IDLE, so changes during another grant are ignored.
  assign req[REQ_I] = bus.i_read;
  assign req[REQ_D] = bus.d_read | bus.d_write;

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  // State and latched-request registers; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_D;  // I wins the first tie after reset
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state: grant and latch in IDLE, release on pmem_resp in either busy state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          if (gnt[REQ_I]) begin
            state_d = BUSY_I;
            op_d    = OP_READ;
            addr_d  = bus.i_address;
            wdata_d = '0;
          end else begin
            state_d = BUSY_D;
            op_d    = d_op(bus.d_read, bus.d_write);
            addr_d  = bus.d_address;
            wdata_d = bus.d_wdata;
          end
        end
      end
      BUSY_I: begin
        if (bus.pmem_resp) begin
          state_d = IDLE;
          last_d  = GRANT_I;
        end
      end
      BUSY_D: begin
        if (bus.pmem_resp) begin
          state_d = IDLE;
          last_d  = GRANT_D;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Memory-side outputs come only from latched registers, so they are stable for the grant.
  // A single latched op guarantees read and write are never asserted together.
  always_comb begin
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    if (busy) begin
      bus.pmem_read    = (op_q == OP_READ);
      bus.pmem_write   = (op_q == OP_WRITE);
      bus.pmem_address = addr_q;
      bus.pmem_wdata   = wdata_q;
    end
  end

  // Response routing: only the granted client sees resp; rdata is zero whenever resp is low.
  // pmem_resp in IDLE falls through both branches and is dropped.
  always_comb begin
    bus.i_resp  = 1'b0;
    bus.i_rdata = '0;
    bus.d_resp  = 1'b0;
    bus.d_rdata = '0;
    if (bus.pmem_resp) begin
      if (state_q == BUSY_I) begin
        bus.i_resp  = 1'b1;
        bus.i_rdata = bus.pmem_rdata;
      end else if (state_q == BUSY_D) begin
        bus.d_resp  = 1'b1;
        bus.d_rdata = bus.pmem_rdata;
      end
    end
  end

endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Shares one physical-memory cacheline port between the instruction cache (read-only client "i") and the data cache (read/write client "d").
- Sits between the two L1 caches and main memory/L2, below the multicycle CPU control path.
- Grants one client at a time, latches that client's request, and drives the shared port until the memory responds. Then it routes the response back and releases the port.
- Fair round-robin between the clients when both request at once.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cacheline width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line data to I-cache
- i_resp  out  1  I-cache completion pulse
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write request
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback data
- d_rdata  out  LINE_W  line data to D-cache
- d_resp  out  1  D-cache completion pulse
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory completion pulse

Behaviour:

States:
- IDLE: no port activity.
- BUSY_I: serving the I-cache.
- BUSY_D: serving the D-cache.
- Extra internal state: last_grant, 1 bit, 0 = I, 1 = D.

Reset (rst = 1 at posedge):
- State goes to IDLE and last_grant to D, so I wins the first tie.
- All latched registers clear.
- All outputs read 0 from the next cycle: pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp, i_rdata, d_rdata.
- Reset mid-transaction abandons the transaction with no resp pulse. Memory is reset alongside.

IDLE transitions:
- Only i pending (i_read): latch i_address, read op, go BUSY_I.
- Only d pending (d_read | d_write): latch d_address, d_wdata and op, go BUSY_D.
- Both pending: grant the client opposite last_grant.
- None pending: stay in IDLE.

BUSY_x (x = i or d):
- pmem_read / pmem_write follow the latched op. pmem_address and pmem_wdata come from the latched registers and are stable for the whole grant.
- pmem_resp = 1: pulse x_resp = 1 in that same cycle, with x_rdata = pmem_rdata combinationally. Set last_grant = x and go to IDLE.
- pmem_resp = 0: hold all outputs and stay in BUSY_x.

Response routing:
- The non-granted client's resp is always 0, including when pmem_resp arrives.
- i_rdata and d_rdata are 0 whenever the respective resp is 0.

Latency and bubble:
- A request seen in IDLE at cycle N gives pmem strobe high from cycle N+1.
- Client resp coincides with pmem_resp.
- At least one IDLE cycle separates consecutive grants, so a client has one cycle to drop its request after resp.

Malformed and unexpected inputs:
- d_read and d_write both high: treat as write.
- The arbiter must never assert pmem_read and pmem_write together.
- pmem_resp while in IDLE is ignored and produces no resp.

Client rules:
- A client holds its request and address stable until its resp.
- Changes made during another client's grant are ignored until that client is granted.

Back-to-back starvation guard:
- If both clients re-request continuously, grants must alternate I, D, I, D.

Decomposition:
- Package arbiter_types:
  - enum arb_state_t {IDLE, BUSY_I, BUSY_D}
  - enum arb_op_t {OP_READ, OP_WRITE}
  - enum grant_t {GRANT_I, GRANT_D}
- One sub-module, rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt (one-hot), valid.
- The FSM, latches and response routing stay in cacheline_arbiter.

Test Plan:
1. Reset with i_read = 1 asserted throughout -> all outputs 0 during and in the first cycle after reset. pmem_read = 1 with pmem_address = i_address by the second cycle.
2. Only i_read, i_address = 0x0000_0060; memory responds 5 cycles later with pmem_rdata = {8{32'hDEAD_BEEF}} -> i_resp pulses for exactly 1 cycle with that data, d_resp stays 0.
3. Only d_write, d_address = 0x0000_1000, d_wdata = {8{32'hA5A5_A5A5}} -> pmem_write = 1 with matching address and data, held stable until pmem_resp. d_resp pulses once, pmem_read never asserts.
4. i_read and d_read raised in the same cycle after reset -> I granted first, D second (IDLE bubble between). Holding both continuously for 4 transactions -> grant order I, D, I, D.
5. d_read granted; i_read with i_address = 0x40 arrives mid-grant; pmem_resp returns -> d_resp only, then the I transaction starts with address 0x40.
6. rst asserted 2 cycles into a BUSY_D read -> no d_resp, pmem_read drops next cycle, state IDLE. A fresh d_read afterwards completes normally.
